host_mem_arbiter: RTL and testbench

// Shares the single mem_ctrl host port between instruction fetch (IF) and data memory (DM).
// One line-sized transaction at a time; round-robin grant; request latched into registered host outputs.

---
 rtl/mem_host_pkg.sv | 24 ++
 rtl/host_mem_arbiter_if.sv | 38 +++
 rtl/host_mem_arbiter_rr_arbiter2.sv | 26 ++
 rtl/host_mem_arbiter.sv | 111 +++++++++++
 tb/tb_host_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_host_pkg.sv
// Shared host-port encodings for the mem_ctrl host arbiter and its requesters.
package mem_host_pkg;
  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } host_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_DM = 1'b1
  } requester_t;

  // 2'b11 is reserved and must never win a grant
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction
endpackage

// File: rtl/host_mem_arbiter_if.sv
// Requester (IF/DM) and mem_ctrl host-side signals of the host arbiter.
interface host_mem_arbiter_if #(parameter int LINE_W = 512);
  logic [1:0]        if_op;
  logic [31:0]       if_addr;
  logic [LINE_W-1:0] if_wdata;
  logic [LINE_W-1:0] if_rdata;
  logic              if_rd_valid;
  logic              if_tx_done;

  logic [1:0]        dm_op;
  logic [31:0]       dm_addr;
  logic [LINE_W-1:0] dm_wdata;
  logic [LINE_W-1:0] dm_rdata;
  logic              dm_rd_valid;
  logic              dm_tx_done;

  logic [LINE_W-1:0] DataIn_host;
  logic              tx_done_host;
  logic              rd_valid_host;
  logic [LINE_W-1:0] DataOut_host;
  logic [31:0]       AddrOut_host;
  logic [1:0]        op_host;

  // master: the arbiter itself; slave: requesters plus mem_ctrl
  modport master (
    input  if_op, if_addr, if_wdata, dm_op, dm_addr, dm_wdata,
    input  DataIn_host, tx_done_host, rd_valid_host,
    output if_rdata, if_rd_valid, if_tx_done, dm_rdata, dm_rd_valid, dm_tx_done,
    output DataOut_host, AddrOut_host, op_host
  );

  modport slave (
    output if_op, if_addr, if_wdata, dm_op, dm_addr, dm_wdata,
    output DataIn_host, tx_done_host, rd_valid_host,
    input  if_rdata, if_rd_valid, if_tx_done, dm_rdata, dm_rd_valid, dm_tx_done,
    input  DataOut_host, AddrOut_host, op_host
  );
endinterface

// File: rtl/host_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester.
module rr_arbiter2
  import mem_host_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_if,
  input  logic       req_dm,
  input  logic       accept,
  output requester_t gnt,
  output logic       gnt_valid,
  output requester_t last_grant
);
  always_comb begin
    gnt_valid = req_if | req_dm;
    gnt       = REQ_IF;
    if (req_if && req_dm) gnt = (last_grant == REQ_DM) ? REQ_IF : REQ_DM;
    else if (req_dm)      gnt = REQ_DM;
  end

  // Reset to DM so that IF wins the first tie
  always_ff @(posedge clk) begin
    if (!rst_n)                      last_grant <= REQ_DM;
    else if (accept && gnt_valid)    last_grant <= gnt;
  end
endmodule

// File: rtl/host_mem_arbiter.sv
// Shares the mem_ctrl host port between IF and DM, one line transaction at a time,
// with round-robin grant, registered host outputs and a hung-transfer watchdog.
module host_mem_arbiter
  import mem_host_pkg::*;
#(
  parameter int LINE_W         = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  host_mem_arbiter_if.master bus,
  output logic              busy,
  output logic              timeout_err
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_t        state, state_nx;
  host_op_t          op_q;
  logic [31:0]       addr_q;
  logic [LINE_W-1:0] data_q;
  logic [CNT_W-1:0]  cnt;
  requester_t        gnt, owner;
  logic              gnt_valid, grant_now, wd_fire;
  logic [1:0]        sel_op;
  logic [31:0]       sel_addr;
  logic [LINE_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_if    (op_valid(bus.if_op)),
    .req_dm    (op_valid(bus.dm_op)),
    .accept    (grant_now),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .last_grant(owner)
  );

  assign grant_now = (state == IDLE) && gnt_valid;
  assign sel_op    = (gnt == REQ_IF) ? bus.if_op    : bus.dm_op;
  assign sel_addr  = (gnt == REQ_IF) ? bus.if_addr  : bus.dm_addr;
  assign sel_wdata = (gnt == REQ_IF) ? bus.if_wdata : bus.dm_wdata;

  assign wd_fire = (TIMEOUT_CYCLES != 0) && (state == BUSY) && !bus.tx_done_host && (cnt == CNT_LAST);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_valid) state_nx = BUSY;
      BUSY:    if (bus.tx_done_host || wd_fire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (gnt_valid) begin
          op_q   <= host_op_t'(sel_op);
          addr_q <= sel_addr;
          data_q <= (sel_op == OP_WRITE) ? sel_wdata : '0;
          cnt    <= '0;
        end
        BUSY: begin
          if (bus.tx_done_host || wd_fire) begin
            op_q <= OP_NONE;
            if (wd_fire) timeout_err <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion strobes reach only the owner, and only while a transfer is live
  always_comb begin
    bus.if_rd_valid = 1'b0;
    bus.if_tx_done  = 1'b0;
    bus.dm_rd_valid = 1'b0;
    bus.dm_tx_done  = 1'b0;
    if (rst_n && state == BUSY) begin
      if (owner == REQ_IF) begin
        bus.if_rd_valid = bus.rd_valid_host && !wd_fire;
        bus.if_tx_done  = bus.tx_done_host || wd_fire;
      end else begin
        bus.dm_rd_valid = bus.rd_valid_host && !wd_fire;
        bus.dm_tx_done  = bus.tx_done_host || wd_fire;
      end
    end
  end

  assign bus.if_rdata     = bus.DataIn_host;
  assign bus.dm_rdata     = bus.DataIn_host;
  assign bus.op_host      = op_q;
  assign bus.AddrOut_host = addr_q;
  assign bus.DataOut_host = data_q;
  assign busy             = (state != IDLE);
endmodule

// File: tb/tb_host_mem_arbiter.sv
// Directed bench for host_mem_arbiter with a grant/completion scoreboard.
module tb_host_mem_arbiter;
  import mem_host_pkg::*;

  localparam int LW = 512;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, timeout_err;

  host_mem_arbiter_if #(.LINE_W(LW)) bus ();

  host_mem_arbiter #(.LINE_W(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    requester_t  who;
    logic [1:0]  op;
    logic [31:0] addr;
    logic [LW-1:0] dout;
  } txn_t;

  txn_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.if_op = 2'b00; bus.if_addr = '0; bus.if_wdata = '0;
    bus.dm_op = 2'b00; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.DataIn_host = '0; bus.tx_done_host = 1'b0; bus.rd_valid_host = 1'b0;
  endtask

  task automatic drive_req(input requester_t who, input logic [1:0] op,
                           input logic [31:0] a, input logic [LW-1:0] wd);
    if (who == REQ_IF) begin bus.if_op = op; bus.if_addr = a; bus.if_wdata = wd; end
    else               begin bus.dm_op = op; bus.dm_addr = a; bus.dm_wdata = wd; end
  endtask

  task automatic push_req(input requester_t who, input logic [1:0] op,
                          input logic [31:0] a, input logic [LW-1:0] wd);
    txn_t t;
    drive_req(who, op, a, wd);
    t.who = who; t.op = op; t.addr = a;
    t.dout = (op == OP_WRITE) ? wd : '0;
    exp_q.push_back(t);
  endtask

  task automatic chk_grant(input string tag);
    chk({tag, "_sb_pending"}, (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) begin
      chk({tag, "_op_host"}, bus.op_host, exp_q[0].op);
      chk({tag, "_addr"}, bus.AddrOut_host, exp_q[0].addr);
      chk({tag, "_dout"}, bus.DataOut_host, exp_q[0].dout);
      chk({tag, "_busy"}, busy, 1'b1);
    end
  endtask

  // Drive mem_ctrl completion in the current BUSY cycle and check routing
  task automatic complete(input string tag, input logic rv, input logic [LW-1:0] d);
    txn_t t;
    bus.tx_done_host = 1'b1; bus.rd_valid_host = rv; bus.DataIn_host = d;
    #1;
    chk({tag, "_sb_pending"}, (exp_q.size() > 0), 1'b1);
    if (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      chk({tag, "_if_tx_done"}, bus.if_tx_done, t.who == REQ_IF);
      chk({tag, "_dm_tx_done"}, bus.dm_tx_done, t.who == REQ_DM);
      chk({tag, "_if_rd_valid"}, bus.if_rd_valid, rv && (t.who == REQ_IF));
      chk({tag, "_dm_rd_valid"}, bus.dm_rd_valid, rv && (t.who == REQ_DM));
      if (rv) begin
        chk({tag, "_if_rdata"}, bus.if_rdata, d);
        chk({tag, "_dm_rdata"}, bus.dm_rdata, d);
      end
      nxt;
      bus.tx_done_host = 1'b0; bus.rd_valid_host = 1'b0;
      drive_req(t.who, OP_NONE, '0, '0);
      #1;
      chk({tag, "_op_cleared"}, bus.op_host, OP_NONE);
      chk({tag, "_done_busy"}, busy, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_host_mem_arbiter time limit");
  end

  initial begin
    logic [LW-1:0] rd1, wd3;
    txn_t dropped;
    rd1 = {16{32'h1234_5678}};
    wd3 = {64{8'hA5}};
    idle_inputs();

    // Reset state
    nxt; #1;
    chk("rst_op_host", bus.op_host, OP_NONE);
    chk("rst_addr", bus.AddrOut_host, 32'h0);
    chk("rst_dout", bus.DataOut_host, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_strobes", {bus.if_rd_valid, bus.if_tx_done, bus.dm_rd_valid, bus.dm_tx_done}, 4'b0);
    nxt; rst_n = 1'b1;

    // 1: IF read, one-cycle grant latency, completion after 4 BUSY cycles
    push_req(REQ_IF, OP_READ, 32'h0000_0040, '0);
    nxt; #1;
    chk_grant("t1_grant");
    for (int i = 0; i < 3; i++) begin
      nxt; #1;
      chk_grant("t1_hold");
      chk("t1_no_early_done", bus.if_tx_done, 1'b0);
    end
    complete("t1_done", 1'b1, rd1);
    nxt; #1;
    chk("t1_idle", busy, 1'b0);

    // 2: simultaneous requests from reset: IF, then DM, then IF again
    rst_n = 1'b0; nxt; rst_n = 1'b1;
    push_req(REQ_IF, OP_READ, 32'h0000_1000, '0);
    push_req(REQ_DM, OP_READ, 32'h0000_2000, '0);
    nxt; #1;
    chk_grant("t2_if_first");
    complete("t2_if_done", 1'b1, ~rd1);
    nxt; #1;
    chk("t2_idle_gap", busy, 1'b0);
    nxt; #1;
    chk_grant("t2_dm_second");
    complete("t2_dm_done", 1'b1, rd1 ^ {LW{1'b1}} ^ 512'h5);
    nxt;
    push_req(REQ_IF, OP_READ, 32'h0000_3000, '0);
    push_req(REQ_DM, OP_READ, 32'h0000_4000, '0);
    nxt; #1;
    chk_grant("t2_if_again");
    complete("t2_if2_done", 1'b1, rd1);
    nxt; nxt; #1;
    chk_grant("t2_dm_again");
    complete("t2_dm2_done", 1'b0, '0);
    nxt;

    // 3: DM write, write data held for 6 BUSY cycles
    push_req(REQ_DM, OP_WRITE, 32'h0600_2000, wd3);
    nxt; #1;
    chk_grant("t3_grant");
    for (int i = 0; i < 5; i++) begin
      nxt; #1;
      chk_grant("t3_hold");
    end
    complete("t3_done", 1'b0, '0);
    nxt;

    // 4: watchdog fires on the 8th BUSY cycle; rd_valid suppressed
    push_req(REQ_DM, OP_READ, 32'h0000_8000, '0);
    nxt; #1;
    chk_grant("t4_grant");
    for (int i = 0; i < 6; i++) begin
      nxt; #1;
      chk("t4_no_done", bus.dm_tx_done, 1'b0);
      chk("t4_busy", busy, 1'b1);
    end
    nxt;
    bus.rd_valid_host = 1'b1;
    #1;
    dropped = exp_q.pop_front();
    chk("t4_dm_tx_done", bus.dm_tx_done, dropped.who == REQ_DM);
    chk("t4_dm_rd_valid", bus.dm_rd_valid, 1'b0);
    chk("t4_if_tx_done", bus.if_tx_done, 1'b0);
    nxt;
    bus.rd_valid_host = 1'b0;
    drive_req(REQ_DM, OP_NONE, '0, '0);
    #1;
    chk("t4_timeout_err", timeout_err, 1'b1);
    chk("t4_op_cleared", bus.op_host, OP_NONE);
    nxt; #1;
    chk("t4_busy_drop", busy, 1'b0);
    chk("t4_timeout_sticky", timeout_err, 1'b1);

    // 5: reset mid-BUSY aborts silently; late tx_done dropped; IF wins next tie
    push_req(REQ_IF, OP_READ, 32'h0000_9000, '0);
    nxt; #1;
    chk_grant("t5_grant");
    nxt;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_strobes", {bus.if_rd_valid, bus.if_tx_done, bus.dm_rd_valid, bus.dm_tx_done}, 4'b0);
    nxt;
    dropped = exp_q.pop_front();
    rst_n = 1'b1;
    drive_req(dropped.who, OP_NONE, '0, '0);
    bus.tx_done_host = 1'b1; bus.rd_valid_host = 1'b1;
    #1;
    chk("t5_op_cleared", bus.op_host, OP_NONE);
    chk("t5_busy", busy, 1'b0);
    chk("t5_timeout_cleared", timeout_err, 1'b0);
    chk("t5_late_strobes", {bus.if_rd_valid, bus.if_tx_done, bus.dm_rd_valid, bus.dm_tx_done}, 4'b0);
    nxt;
    bus.tx_done_host = 1'b0; bus.rd_valid_host = 1'b0;
    push_req(REQ_IF, OP_READ, 32'h0000_A000, '0);
    push_req(REQ_DM, OP_WRITE, 32'h0000_B000, ~wd3);
    nxt; #1;
    chk_grant("t5_if_tie");
    complete("t5_if_done", 1'b1, wd3);
    nxt; nxt; #1;
    chk_grant("t5_dm_next");
    complete("t5_dm_done", 1'b0, '0);
    nxt; #1;
    chk("t5_idle", busy, 1'b0);

    // 6: host strobes in IDLE and reserved op 2'b11 are ignored
    nxt;
    bus.if_op = 2'b11; bus.if_addr = 32'hDEAD_0000;
    bus.tx_done_host = 1'b1; bus.rd_valid_host = 1'b1;
    #1;
    chk("t6_idle_strobes", {bus.if_rd_valid, bus.if_tx_done, bus.dm_rd_valid, bus.dm_tx_done}, 4'b0);
    for (int i = 0; i < 2; i++) begin
      nxt; #1;
      chk("t6_busy", busy, 1'b0);
      chk("t6_op_host", bus.op_host, OP_NONE);
    end
    idle_inputs();
    nxt; #1;
    chk("end_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
